// File: rtl/ov2640_cfg_pkg.sv
// OV2640 register-table sequencer: shared states and constants.
// OV2640_SOFT_RESET_EN selects the soft-reset preamble steps.
package ov2640_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PWRUP,
    LOAD,
    START,
    WAIT_ACK,
    GAP,
    DONE,
    ERR
  } cfg_state_t;

  typedef enum logic [1:0] {
    PRE_BANK,
    PRE_COM7,
    PRE_WAIT,
    PRE_TABLE
  } pre_step_t;

  localparam logic [7:0] OV2640_SLAVE_ID = 8'h60;

  localparam logic [7:0] SRST_BANK_ADDR = 8'hFF;
  localparam logic [7:0] SRST_BANK_VAL  = 8'h01;
  localparam logic [7:0] SRST_COM7_ADDR = 8'h12;
  localparam logic [7:0] SRST_COM7_VAL  = 8'h80;

  function automatic int max_w(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov2640_cfg_sequencer_rom.sv
// OV2640 register table, {addr,value} per entry.
// Indices at or beyond TABLE_LEN read as 16'hFFFF.
module ov2640_reg_rom #(
  parameter int TABLE_LEN = 200
) (
  input  logic [7:0]  index,
  output logic [15:0] entry
);

  // table lookup, guarded by table length
  always_comb begin
    entry = 16'hFFFF;
    if (int'(index) < TABLE_LEN) begin
      case (index)
        8'd0:    entry = 16'hFF00;
        8'd1:    entry = 16'h2CFF;
        8'd2:    entry = 16'h2EDF;
        8'd3:    entry = 16'hFF01;
        8'd4:    entry = 16'h3C32;
        8'd5:    entry = 16'h1100;
        8'd6:    entry = 16'h0902;
        8'd7:    entry = 16'h0428;
        8'd8:    entry = 16'h13E5;
        8'd9:    entry = 16'h1448;
        8'd10:   entry = 16'h2C0C;
        8'd11:   entry = 16'h3378;
        default: entry = 16'hFFFF;
      endcase
    end
  end

endmodule

// File: rtl/ov2640_cfg_sequencer.sv
// Walks the OV2640 register table through an SCCB driver.
// OV2640_SOFT_RESET_EN adds a soft-reset preamble.
module ov2640_cfg_sequencer
  import ov2640_cfg_pkg::*;
#(
  parameter logic [7:0] SLAVE_ID     = OV2640_SLAVE_ID,
  parameter int         TABLE_LEN    = 200,
  parameter int         PWRUP_CYCLES = 1_000_000,
  parameter int         GAP_CYCLES   = 70_000,
  parameter int         ACK_TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       sccb_ok,
  output logic       cfg_ok,
  output logic [7:0] slave_id,
  output logic [7:0] cfg_addr,
  output logic [7:0] value,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [7:0] index
);

  localparam int PW_W = $clog2(PWRUP_CYCLES + 1);
  localparam int GP_W = $clog2(GAP_CYCLES + 1);
  localparam int AK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int CW   = max_w(max_w(PW_W, GP_W), AK_W);

  localparam logic [CW-1:0] PW_LAST =
    CW'((PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GP_LAST =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] AK_LAST =
    CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [7:0] IDX_LAST = 8'(TABLE_LEN - 1);

  cfg_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    idx, idx_n;
  logic [7:0]    addr_n, val_n;
  logic [15:0]   rom_entry;
`ifdef OV2640_SOFT_RESET_EN
  pre_step_t     pre, pre_n;
`endif

  ov2640_reg_rom #(
    .TABLE_LEN(TABLE_LEN)
  ) u_rom (
    .index(idx),
    .entry(rom_entry)
  );

  // state, counter and presented-write registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PWRUP;
      cnt      <= '0;
      idx      <= '0;
      cfg_addr <= '0;
      value    <= '0;
`ifdef OV2640_SOFT_RESET_EN
      pre      <= PRE_BANK;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      cfg_addr <= addr_n;
      value    <= val_n;
`ifdef OV2640_SOFT_RESET_EN
      pre      <= pre_n;
`endif
    end
  end

  // next-state, counters and table stepping
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    addr_n  = cfg_addr;
    val_n   = value;
`ifdef OV2640_SOFT_RESET_EN
    pre_n   = pre;
`endif
    unique case (state)
      PWRUP: begin
        if (cnt >= PW_LAST) begin
          state_n = LOAD;
          cnt_n   = '0;
          idx_n   = '0;
`ifdef OV2640_SOFT_RESET_EN
          if (pre == PRE_WAIT) pre_n = PRE_TABLE;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LOAD: begin
        state_n         = START;
        {addr_n, val_n} = rom_entry;
`ifdef OV2640_SOFT_RESET_EN
        if (pre == PRE_BANK)
          {addr_n, val_n} = {SRST_BANK_ADDR, SRST_BANK_VAL};
        else if (pre == PRE_COM7)
          {addr_n, val_n} = {SRST_COM7_ADDR, SRST_COM7_VAL};
`endif
      end
      START: begin
        state_n = WAIT_ACK;
        cnt_n   = CW'(1);
      end
      WAIT_ACK: begin
        if (sccb_ok) begin
          state_n = GAP;
          cnt_n   = '0;
        end else if (cnt >= AK_LAST) begin
          state_n = ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt >= GP_LAST) begin
          cnt_n = '0;
`ifdef OV2640_SOFT_RESET_EN
          if (pre == PRE_BANK) begin
            pre_n   = PRE_COM7;
            state_n = LOAD;
          end else if (pre == PRE_COM7) begin
            pre_n   = PRE_WAIT;
            state_n = PWRUP;
          end else
`endif
          if (idx >= IDX_LAST) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = LOAD;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (restart) begin
      state_n = PWRUP;
      cnt_n   = '0;
      idx_n   = '0;
`ifdef OV2640_SOFT_RESET_EN
      pre_n   = PRE_BANK;
`endif
    end
  end

  assign cfg_ok   = (state == START);
  assign slave_id = SLAVE_ID;
  assign busy     = !(state == IDLE || state == DONE || state == ERR);
  assign cfg_done = (state == DONE);
  assign cfg_err  = (state == ERR);
  assign index    = idx;

endmodule
